carousel_ctrl: RTL
==================

# carousel_ctrl

Sequencer for a rotating register bank of BUFFER_SIZE lanes (a carousel). It accepts one vector load from upstream and issues the bank's load strobe. It then presents a configurable number of rotation phases to a downstream consumer, issuing one shift strobe per accepted phase except the last. It sits between the producer handshake and the carousel datapath, which holds no control state of its own.

## Interface
- BUFFER_SIZE, 16, lanes in the carousel; must be ≥ 2.
- CNT_W, $clog2(BUFFER_SIZE+1), derived; width of the rotation-count configuration.
- IDX_W, $clog2(BUFFER_SIZE), derived; width of the phase index.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cfg_rotations  in  CNT_W  phases per load; sampled only on a load handshake.
- abort  in  1  synchronous flush of the current job.
- in_valid  in  1  upstream vector available.
- in_ready  out  1  controller can accept a load.
- bank_load  out  1  one-cycle strobe: capture upstream vector into the bank.
- bank_shift  out  1  one-cycle strobe: rotate the bank by one lane.
- out_valid  out  1  current bank contents form a valid phase.
- out_ready  in  1  downstream accepts the phase.
- out_last  out  1  current phase is the final one of the job.
- out_index  out  IDX_W  number of shifts applied since the load.
- busy  out  1  job in progress (state is not IDLE).

## Operation
- States: IDLE, PRESENT.
- IDLE
  - in_ready = !abort.
  - A load handshake (in_valid & in_ready) asserts bank_load combinationally.
  - On the handshake: latch the effective count, set out_index = 0, go to PRESENT.
- Effective count:
  - cfg_rotations == 0 → BUFFER_SIZE.
  - cfg_rotations > BUFFER_SIZE → BUFFER_SIZE.
  - Otherwise the value as given.
- PRESENT: out_valid = 1, out_last = (out_index == count−1).
- Output handshake (out_valid & out_ready), not last:
  - bank_shift = 1 in that cycle.
  - out_index increments; state stays PRESENT.
- Output handshake on the last phase:
  - No bank_shift.
  - in_ready = out_ready & !abort. This allows a back-to-back load with bank_load in the same cycle.
  - If a load occurs: re-latch the count, out_index = 0, stay PRESENT.
  - Otherwise go to IDLE.
- out_ready low: hold out_index, out_valid and state; no strobes.
- abort
  - Highest priority.
  - In PRESENT: bank_shift = 0, bank_load = 0, in_ready = 0; go to IDLE next cycle, no out_last handshake.
  - In IDLE: blocks that cycle's load.
- out_index never wraps. Maximum value is BUFFER_SIZE−1.
- Count arithmetic is unsigned CNT_W. The comparison uses count−1 at CNT_W, with no overflow because count ≥ 1.

## Timing
- While rst is high:
  - state = IDLE, count = BUFFER_SIZE, out_index = 0.
  - out_valid, out_last, busy, bank_load, bank_shift, in_ready all 0.
- in_ready rises in the first cycle after rst deasserts.
- Registered: state, count, out_index. out_valid, out_last and busy are decoded from those registers only.
- Combinational (Mealy): in_ready, bank_load, bank_shift.
  - in_ready has a combinational path from out_ready on the last phase; document this at integration.
- Load-to-first-phase latency: 1 cycle (out_valid in the cycle after bank_load).
- Throughput: 1 phase per cycle with out_ready held high. Back-to-back jobs have no idle bubble.
- Rotation visibility: the bank updates at the edge ending the bank_shift cycle. The new contents and the incremented out_index appear together in the next cycle.
- rst asserted mid-job: immediate return to IDLE with no strobes, regardless of the clock.

## Structure
- Package carousel_ctrl_pkg:
  - state enum typedef (IDLE, PRESENT).
  - Function computing the effective count from cfg_rotations and BUFFER_SIZE.
- One sub-module, carousel_phase_counter:
  - Loadable IDX_W up-counter with latched count and last-phase compare.
  - The top level holds the FSM and strobe decode.

## Test plan
- Reset, cfg_rotations=4, in_valid pulse, out_ready=1 → bank_load at T0. out_valid T1–T4 with out_index 0,1,2,3. bank_shift at T1–T3. out_last at T4 only. in_ready=1 at T5.
- Same job with out_ready low T2–T4 → out_index holds at 1, no bank_shift T2–T4, job ends 3 cycles later.
- cfg_rotations=0 and separately cfg_rotations=20 → 16 phases, 15 shifts, out_last at out_index 15.
- in_valid held high with out_ready=1, cfg=2 → bank_load every 2nd cycle coincident with out_last. out_valid continuously high, out_index alternates 0,1.
- abort asserted at out_index=2 → no bank_shift that cycle. Next cycle out_valid=0, busy=0, in_ready=1. out_last never seen.
- rst pulsed asynchronously (mid-cycle) at out_index=3 → all outputs 0 during rst. After release: IDLE, in_ready=1, out_index=0.

Source files
------------

// File: rtl/carousel_ctrl_pkg.sv
// Shared types and helpers for the carousel sequencer.
//   state_t        : controller state encoding
//   eff_count()    : maps a raw rotation request onto the number of phases a job presents
package carousel_ctrl_pkg;

    localparam int unsigned BUFFER_SIZE_DEF = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Zero or out-of-range requests mean "one full revolution of the bank".
    function automatic int unsigned eff_count(input int unsigned cfg, input int unsigned size);
        if (cfg == 0 || cfg > size) begin
            return size;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/carousel_phase_counter.sv
// Loadable phase index counter with latched job length and final-phase compare.
//   clk, rst      : clock, async active-high reset
//   i_load        : start a job: latch i_count, zero the index
//   i_count       : effective phase count (1..BUFFER_SIZE)
//   i_inc         : advance to the next phase
//   i_clear       : zero the index (job ended or flushed)
//   o_index       : shifts applied since the load
//   o_last        : index is the final phase of the latched count
module carousel_phase_counter #(
    parameter int unsigned BUFFER_SIZE = 16,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [IDX_W-1:0] o_index,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_index;

    // Load has priority; inc is only issued on non-final phases so the index never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= CNT_W'(BUFFER_SIZE);
            r_index <= '0;
        end else if (i_load) begin
            r_count <= i_count;
            r_index <= '0;
        end else if (i_clear) begin
            r_index <= '0;
        end else if (i_inc) begin
            r_index <= r_index + IDX_W'(1);
        end
    end

    // count is always >= 1, so count-1 cannot underflow.
    assign o_last  = (CNT_W'(r_index) == (r_count - CNT_W'(1)));
    assign o_index = r_index;

endmodule

// File: rtl/carousel_ctrl.sv
// Carousel sequencer: accepts a vector load, then presents rotation phases downstream.
//   clk, rst        : clock, async active-high reset
//   cfg_rotations   : phases per job, sampled on the load handshake
//   abort           : synchronous flush of the current job
//   in_valid/ready  : upstream load handshake (in_ready is combinational, incl. from out_ready)
//   bank_load       : strobe, capture upstream vector into the bank
//   bank_shift      : strobe, rotate the bank by one lane
//   out_valid/ready : downstream phase handshake
//   out_last        : final phase of the job
//   out_index       : shifts applied since the load
//   busy            : job in progress
module carousel_ctrl
    import carousel_ctrl_pkg::*;
#(
    parameter  int unsigned BUFFER_SIZE = BUFFER_SIZE_DEF,
    localparam int unsigned CNT_W       = $clog2(BUFFER_SIZE + 1),
    localparam int unsigned IDX_W       = $clog2(BUFFER_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_rotations,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bank_load,
    output logic             bank_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [IDX_W-1:0] out_index,
    output logic             busy
);

    state_t           r_state;
    logic             w_present;
    logic             w_last;
    logic             w_final_hs;
    logic             w_clear;
    logic [CNT_W-1:0] w_count;

    assign w_present  = (r_state == ST_PRESENT);
    assign w_final_hs = w_present & out_ready & w_last & ~abort;

    // Accept a load when idle, or back-to-back on the final accepted phase; reset and abort block it.
    assign in_ready   = ~rst & ~abort & (~w_present | (out_ready & w_last));
    assign bank_load  = in_valid & in_ready;
    assign bank_shift = w_present & out_ready & ~w_last & ~abort;

    assign w_count    = CNT_W'(eff_count(32'(cfg_rotations), BUFFER_SIZE));
    assign w_clear    = abort | (w_final_hs & ~bank_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (abort) begin
            r_state <= ST_IDLE;
        end else if (bank_load) begin
            r_state <= ST_PRESENT;
        end else if (w_final_hs) begin
            r_state <= ST_IDLE;
        end
    end

    carousel_phase_counter #(
        .BUFFER_SIZE (BUFFER_SIZE),
        .CNT_W       (CNT_W),
        .IDX_W       (IDX_W)
    ) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .i_load  (bank_load),
        .i_count (w_count),
        .i_inc   (bank_shift),
        .i_clear (w_clear),
        .o_index (out_index),
        .o_last  (w_last)
    );

    assign out_valid = w_present;
    assign out_last  = w_present & w_last;
    assign busy      = w_present;

endmodule
